// File: rtl/dispatch_stage.sv
// dispatch_stage: single-entry registered dispatch between issue and the
// execution queues (RS for arithmetic/branch, LSB for load/store).
// The held entry keeps snooping both CDBs so its operands never go stale.
// Optional macro DISPATCH_OUT_BYPASS_EN: forward the current-cycle CDB onto
// out_Q*/out_V* so a tag broadcast in the fire cycle reaches RS/LSB resolved.
module dispatch_stage #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_ls,
  input  logic [OP_W-1:0]     in_op,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  input  logic [4:0]          in_rd,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [ROB_ID_W-1:0] in_Q1,
  input  logic [ROB_ID_W-1:0] in_Q2,
  input  logic [DATA_W-1:0]   in_V1,
  input  logic [DATA_W-1:0]   in_V2,
  input  logic                cdb_alu_valid,
  input  logic [ROB_ID_W-1:0] cdb_alu_id,
  input  logic [DATA_W-1:0]   cdb_alu_result,
  input  logic                cdb_ls_valid,
  input  logic [ROB_ID_W-1:0] cdb_ls_id,
  input  logic [DATA_W-1:0]   cdb_ls_result,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                rs_valid,
  output logic                lsb_valid,
  output logic [OP_W-1:0]     out_op,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic [4:0]          out_rd,
  output logic [DATA_W-1:0]   out_imm,
  output logic [DATA_W-1:0]   out_pc,
  output logic [ROB_ID_W-1:0] out_Q1,
  output logic [ROB_ID_W-1:0] out_Q2,
  output logic [DATA_W-1:0]   out_V1,
  output logic [DATA_W-1:0]   out_V2
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  is_ls_q, is_ls_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [ROB_ID_W-1:0]   rob_id_q, rob_id_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic [ROB_ID_W-1:0]   q1_q, q1_d, q2_q, q2_d;
  logic [DATA_W-1:0]     v1_q, v1_d, v2_q, v2_d;

  logic hold_valid, tgt_full, fire, accept;

  // Resolve one operand against the CDBs: ALU wins, tag 0 never matches.
  function automatic logic [ROB_ID_W+DATA_W-1:0] snoop(
    input logic [ROB_ID_W-1:0] q,
    input logic [DATA_W-1:0]   v
  );
    if (q != '0 && cdb_alu_valid && q == cdb_alu_id)
      return {{ROB_ID_W{1'b0}}, cdb_alu_result};
    else if (q != '0 && cdb_ls_valid && q == cdb_ls_id)
      return {{ROB_ID_W{1'b0}}, cdb_ls_result};
    else
      return {q, v};
  endfunction

  assign hold_valid = (state_q == HELD);
  assign tgt_full   = is_ls_q ? lsb_full : rs_full;

  // Handshake: fire drains the entry, ready allows same-cycle refill.
  always_comb begin
    fire      = rst_n & rdy & hold_valid & ~tgt_full & ~flush;
    in_ready  = rst_n & rdy & ~flush & (~hold_valid | fire);
    accept    = in_valid & in_ready;
    rs_valid  = fire & ~is_ls_q;
    lsb_valid = fire & is_ls_q;
  end

  // Next state: flush > accept (load/replace) > fire (drain) > snoop.
  always_comb begin
    state_d  = state_q;
    is_ls_d  = is_ls_q;
    op_d     = op_q;
    rob_id_d = rob_id_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    q1_d     = q1_q;
    q2_d     = q2_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d  = HELD;
      is_ls_d  = in_is_ls;
      op_d     = in_op;
      rob_id_d = in_rob_id;
      rd_d     = in_rd;
      imm_d    = in_imm;
      pc_d     = in_pc;
      q1_d     = in_Q1;
      q2_d     = in_Q2;
      v1_d     = in_V1;
      v2_d     = in_V2;
    end else if (fire) begin
      state_d = EMPTY;
    end else if (hold_valid) begin
      // Snoop runs even when rdy is low so no broadcast is lost.
      {q1_d, v1_d} = snoop(q1_q, v1_q);
      {q2_d, v2_d} = snoop(q2_q, v2_q);
    end
  end

  // State and payload registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      is_ls_q  <= 1'b0;
      op_q     <= '0;
      rob_id_q <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      q1_q     <= '0;
      q2_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_ls_q  <= is_ls_d;
      op_q     <= op_d;
      rob_id_q <= rob_id_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
    end
  end

  assign out_op     = op_q;
  assign out_rob_id = rob_id_q;
  assign out_rd     = rd_q;
  assign out_imm    = imm_q;
  assign out_pc     = pc_q;

`ifdef DISPATCH_OUT_BYPASS_EN
  // Forward the current-cycle CDB so the consumer sees resolved operands.
  always_comb begin
    {out_Q1, out_V1} = snoop(q1_q, v1_q);
    {out_Q2, out_V2} = snoop(q2_q, v2_q);
  end
`else
  // Registered operands; the consumer snoops the fire-cycle CDB itself.
  always_comb begin
    out_Q1 = q1_q;
    out_V1 = v1_q;
    out_Q2 = q2_q;
    out_V2 = v2_q;
  end
`endif

endmodule
